// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Owner codes tag which requester holds the SRAM port this cycle.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_EXT  = 2'd2;

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// Saturating starvation counter for the external requester.
// at_limit rises once the external side has lost STARVE_LIMIT cycles.
module arb_starve_cnt #(
  parameter int CNT_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;

  // A zero limit means ext always wins, so skip the comparator.
  generate
    if (STARVE_LIMIT == 0) begin : g_zero
      assign at_limit = 1'b1;
    end else begin : g_cmp
      assign at_limit = (cnt >= LIMIT);
    end
  endgenerate

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data SRAM arbiter between CPU MEM stage and debug/DMA port.
// CPU has priority; a starvation counter forces an occasional ext grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic       starved;
  logic       force_ext;
  logic       grant_cpu;
  logic       grant_ext;
  logic       rd_cpu;
  logic       rd_ext;
  logic [1:0] owner;

  assign force_ext = ext_req & starved;
  assign grant_cpu = cpu_req & enable & ~force_ext;
  assign grant_ext = ext_req & ~grant_cpu;
  assign ext_gnt   = grant_ext;
  assign cpu_stall = cpu_req & enable & ~grant_cpu;

  arb_starve_cnt #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr      (~ext_req | grant_ext),
    .inc      (ext_req & ~grant_ext),
    .at_limit (starved)
  );

  always_comb begin
    owner = OWN_NONE;
    unique case (1'b1)
      grant_cpu: owner = OWN_CPU;
      grant_ext: owner = OWN_EXT;
      default:   owner = OWN_NONE;
    endcase
  end

  // Idle port drives zeros so the SRAM sees quiet inputs.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    unique case (owner)
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wen   = cpu_we;
        mem_ren   = ~cpu_we;
      end
      OWN_EXT: begin
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        mem_wen   = ext_we;
        mem_ren   = ~ext_we;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_cpu <= 1'b0;
      rd_ext <= 1'b0;
    end else begin
      rd_cpu <= grant_cpu & ~cpu_we;
      rd_ext <= grant_ext & ~ext_we;
    end
  end

  assign cpu_rvalid = rd_cpu;
  assign ext_rvalid = rd_ext;
  assign cpu_rdata  = rd_cpu ? mem_rdata : '0;
  assign ext_rdata  = rd_ext ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with an SRAM model and read scoreboard.
// A second instance covers the zero starvation limit.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          enable = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          ext_req = 1'b0;
  logic          ext_we = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_wdata = '0;

  logic          cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [DW-1:0] cpu_rdata, ext_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wen, mem_ren;
  logic [DW-1:0] mem_rdata = '0;

  logic          z_cpu_stall, z_cpu_rvalid, z_ext_gnt, z_ext_rvalid;
  logic [DW-1:0] z_cpu_rdata, z_ext_rdata, z_mem_wdata;
  logic [AW-1:0] z_mem_addr;
  logic          z_mem_wen, z_mem_ren;
  logic [DW-1:0] z_mem_rdata = '0;

  logic [DW-1:0] sram  [0:(1<<AW)-1];
  logic [DW-1:0] model [0:(1<<AW)-1];
  logic [DW-1:0] cpu_q [$];
  logic [DW-1:0] ext_q [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_addr];
  end

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .CNT_W(3)
  ) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(0), .CNT_W(1)
  ) dut_z (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(z_cpu_stall), .cpu_rvalid(z_cpu_rvalid),
    .cpu_rdata(z_cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(z_ext_gnt), .ext_rvalid(z_ext_rvalid),
    .ext_rdata(z_ext_rdata),
    .mem_addr(z_mem_addr), .mem_wen(z_mem_wen),
    .mem_ren(z_mem_ren), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic ret(input logic cv, input logic ev);
    logic [DW-1:0] e;
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(cv));
    chk("ext_rvalid", 32'(ext_rvalid), 32'(ev));
    e = '0;
    if (cv && cpu_q.size() > 0) e = cpu_q.pop_front();
    chk("cpu_rdata", cpu_rdata, e);
    e = '0;
    if (ev && ext_q.size() > 0) e = ext_q.pop_front();
    chk("ext_rdata", ext_rdata, e);
  endtask

  function automatic logic [DW-1:0] cnt_now();
    return 32'(dut.u_starve.cnt);
  endfunction

  initial begin
    logic [AW-1:0] pa [6];
    logic [DW-1:0] pd [6];
    pa = '{10'd1, 10'd2, 10'd3, 10'd5, 10'd7, 10'd9};
    pd = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
           32'hDEAD_BEEF, 32'h0BAD_0007, 32'h9999_0009};

    settle();
    chk("rst_cpu_stall", 32'(cpu_stall), 0);
    chk("rst_ext_gnt", 32'(ext_gnt), 0);
    chk("rst_mem_wen", 32'(mem_wen), 0);
    chk("rst_mem_ren", 32'(mem_ren), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cnt", cnt_now(), 0);
    ret(1'b0, 1'b0);
    tick(); arst_n = 1'b1;

    // preload through the ext port with the CPU halted
    for (int i = 0; i < 6; i++) begin
      tick(); idle(); enable = 1'b0;
      ext_req = 1'b1; ext_we = 1'b1;
      ext_addr = pa[i]; ext_wdata = pd[i];
      settle();
      chk("pre_gnt", 32'(ext_gnt), 1);
      chk("pre_wen", 32'(mem_wen), 1);
      chk("pre_addr", 32'(mem_addr), 32'(pa[i]));
      chk("pre_wdata", mem_wdata, pd[i]);
      model[pa[i]] = pd[i];
    end

    // single CPU read
    tick(); idle(); enable = 1'b1;
    cpu_req = 1'b1; cpu_addr = 10'd5;
    settle();
    chk("t1_ren", 32'(mem_ren), 1);
    chk("t1_wen", 32'(mem_wen), 0);
    chk("t1_addr", 32'(mem_addr), 5);
    chk("t1_stall", 32'(cpu_stall), 0);
    cpu_q.push_back(32'hDEAD_BEEF);
    ret(1'b0, 1'b0);
    tick(); idle(); settle();
    ret(1'b1, 1'b0);
    chk("t1_idle_ren", 32'(mem_ren), 0);
    chk("t1_idle_addr", 32'(mem_addr), 0);

    // back-to-back CPU reads
    for (int i = 1; i <= 3; i++) begin
      tick(); idle(); cpu_req = 1'b1; cpu_addr = AW'(i);
      settle();
      chk("t4_stall", 32'(cpu_stall), 0);
      chk("t4_addr", 32'(mem_addr), 32'(i));
      ret(i != 1, 1'b0);
      cpu_q.push_back(model[i]);
    end
    tick(); idle(); settle();
    ret(1'b1, 1'b0);

    // starvation forces ext write on the fifth requesting cycle
    for (int c = 0; c <= 5; c++) begin
      tick(); idle();
      cpu_req = 1'b1;
      cpu_addr = (c == 5) ? 10'd7 : 10'd9;
      ext_req = (c < 5); ext_we = 1'b1;
      ext_addr = 10'd7; ext_wdata = 32'h1234;
      settle();
      chk("t2_cnt", cnt_now(), (c < 5) ? 32'(c) : 0);
      chk("t2_gnt", 32'(ext_gnt), 32'(c == 4));
      chk("t2_stall", 32'(cpu_stall), 32'(c == 4));
      ret(c >= 1 && c <= 4, 1'b0);
      if (c == 4) begin
        chk("t2_wen", 32'(mem_wen), 1);
        chk("t2_addr", 32'(mem_addr), 7);
        chk("t2_wdata", mem_wdata, 32'h1234);
        model[7] = 32'h1234;
      end else begin
        cpu_q.push_back(model[cpu_addr]);
      end
    end
    tick(); idle(); settle();
    ret(1'b1, 1'b0);

    // forced ext read beats a same-address CPU write
    for (int c = 0; c <= 6; c++) begin
      tick(); idle(); cpu_req = 1'b1;
      if (c < 4) begin
        cpu_addr = 10'd1;
      end else if (c < 6) begin
        cpu_we = 1'b1; cpu_addr = 10'd2; cpu_wdata = 32'hA5A5_A5A5;
      end else begin
        cpu_addr = 10'd2;
      end
      ext_req = (c < 5); ext_addr = 10'd2;
      settle();
      if (c < 4) begin
        ret(c > 0, 1'b0);
        cpu_q.push_back(model[1]);
      end else if (c == 4) begin
        ret(1'b1, 1'b0);
        chk("rw_gnt", 32'(ext_gnt), 1);
        chk("rw_stall", 32'(cpu_stall), 1);
        chk("rw_ren", 32'(mem_ren), 1);
        ext_q.push_back(model[2]);
      end else if (c == 5) begin
        ret(1'b0, 1'b1);
        chk("rw_stall2", 32'(cpu_stall), 0);
        chk("rw_wen", 32'(mem_wen), 1);
        model[2] = 32'hA5A5_A5A5;
      end else begin
        ret(1'b0, 1'b0);
        cpu_q.push_back(model[2]);
      end
    end
    tick(); idle(); settle();
    ret(1'b1, 1'b0);

    // CPU halted: ext owns the memory
    for (int c = 0; c <= 1; c++) begin
      tick(); idle(); enable = 1'b0;
      cpu_req = 1'b1; cpu_addr = 10'd1;
      ext_req = 1'b1; ext_addr = 10'd3;
      settle();
      chk("t3_gnt", 32'(ext_gnt), 1);
      chk("t3_stall", 32'(cpu_stall), 0);
      chk("t3_addr", 32'(mem_addr), 3);
      chk("t3_cnt", cnt_now(), 0);
      ret(1'b0, c == 1);
      ext_q.push_back(model[3]);
    end
    tick(); idle(); enable = 1'b1; settle();
    ret(1'b0, 1'b1);

    // reset between a forced ext read grant and its return
    for (int c = 0; c <= 4; c++) begin
      tick(); idle();
      cpu_req = 1'b1; cpu_addr = 10'd1;
      ext_req = 1'b1; ext_addr = 10'd5;
      settle();
      ret(c >= 1, 1'b0);
      if (c < 4) cpu_q.push_back(model[1]);
    end
    chk("t5_gnt", 32'(ext_gnt), 1);
    #2 arst_n = 1'b0;
    settle();
    chk("t5_cnt_async", cnt_now(), 0);
    tick(); idle(); settle();
    chk("t5_rvalid", 32'(ext_rvalid), 0);
    chk("t5_cnt", cnt_now(), 0);
    chk("t5_addr", 32'(mem_addr), 0);
    arst_n = 1'b1;
    tick(); settle();
    ret(1'b0, 1'b0);

    // pending return dropped the moment reset asserts
    tick(); cpu_req = 1'b1; cpu_addr = 10'd3; settle();
    cpu_q.push_back(model[3]);
    tick(); idle(); settle();
    ret(1'b1, 1'b0);
    arst_n = 1'b0; settle();
    chk("t5_drop_v", 32'(cpu_rvalid), 0);
    chk("t5_drop_d", cpu_rdata, 0);
    tick(); arst_n = 1'b1;

    // zero limit: ext wins every cycle
    for (int c = 0; c < 4; c++) begin
      tick(); idle();
      cpu_req = 1'b1; cpu_addr = AW'(c);
      ext_req = 1'b1; ext_we = 1'b1;
      ext_addr = AW'(c + 20); ext_wdata = 32'(c);
      settle();
      chk("t6_gnt", 32'(z_ext_gnt), 1);
      chk("t6_stall", 32'(z_cpu_stall), 1);
      chk("t6_addr", 32'(z_mem_addr), 32'(c + 20));
    end
    tick(); idle(); settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
